// File: rtl/pipe_ctrl_pkg.sv
// Shared types and control encodings for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } state_t;

  localparam int DEF_REG_AW = 5;

  // Pipeline-register controls driven every cycle; field order is the output bus order.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = 6'b110100;  // free-running pipeline
  localparam ctrl_t CTRL_STOP   = 6'b001011;  // everything frozen and cleared
  localparam ctrl_t CTRL_HOLD   = 6'b000001;  // mul/div occupies EX, bubble into MEM
  localparam ctrl_t CTRL_BUBBLE = 6'b000110;  // freeze front end, bubble into EX
  localparam ctrl_t CTRL_BRANCH = 6'b111111;  // redirect PC, squash wrong path

endpackage

// File: rtl/pipe_hazard_cmp.sv
// Load-use hazard detector: a load in EX whose destination is read by the instruction in ID.
module pipe_hazard_cmp #(
  parameter int REG_AW = 5
) (
  input  logic              memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              lu_hazard
);

  // $zero is never really written, so a load into it cannot create a dependency.
  assign lu_hazard = memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: branch flush, mul/div hold,
// load-use stall and halt drain, plus saturating stall/flush event counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LAT    = 4,
  parameter int DRAIN_CYC = 3,
  parameter int REG_AW    = DEF_REG_AW,
  parameter int CNT_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] ifid_rs_i,
  input  logic [REG_AW-1:0] ifid_rt_i,
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rt_i,
  input  logic              idex_is_md_i,
  input  logic              branch_taken_i,
  input  logic              halt_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_write_o,
  output logic              idex_flush_o,
  output logic              exmem_flush_o,
  output logic              md_done_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam int MD_W = $clog2(MD_LAT + 1);
  localparam int DR_W = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LAT - 1);
  localparam logic [DR_W-1:0] DR_LOAD = DR_W'(DRAIN_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t          state;
  state_t          state_nxt;
  logic [MD_W-1:0] md_cnt;
  logic [MD_W-1:0] md_cnt_nxt;
  logic [DR_W-1:0] drain_cnt;
  logic [DR_W-1:0] drain_nxt;
  ctrl_t           ctrl;
  logic            md_done;
  logic            stall_evt;
  logic            flush_evt;
  logic            lu_hazard;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  pipe_hazard_cmp #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .memread   (idex_memread_i),
    .ex_rt     (idex_rt_i),
    .id_rs     (ifid_rs_i),
    .id_rt     (ifid_rt_i),
    .lu_hazard (lu_hazard)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= RUN;
      md_cnt    <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      md_cnt    <= md_cnt_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    drain_nxt  = drain_cnt;
    ctrl       = CTRL_RUN;
    md_done    = 1'b0;
    stall_evt  = 1'b0;
    flush_evt  = 1'b0;

    if (state == HALTED) begin
      ctrl = CTRL_STOP;
    end else if (branch_taken_i) begin
      // A taken branch wins everywhere below HALTED; a wrong-path mul/div or drain is abandoned.
      ctrl       = CTRL_BRANCH;
      flush_evt  = 1'b1;
      state_nxt  = RUN;
      md_cnt_nxt = '0;
      drain_nxt  = '0;
    end else begin
      case (state)
        RUN: begin
          if (idex_is_md_i) begin
            // The first EX cycle of the op already holds the front end.
            ctrl       = CTRL_HOLD;
            stall_evt  = 1'b1;
            md_cnt_nxt = MD_LOAD;
            state_nxt  = MD_BUSY;
          end else if (lu_hazard) begin
            ctrl      = CTRL_BUBBLE;
            stall_evt = 1'b1;
          end else if (halt_i) begin
            drain_nxt = DR_LOAD;
            state_nxt = DRAIN;
          end
        end
        MD_BUSY: begin
          if (md_cnt <= MD_W'(1)) begin
            md_done    = 1'b1;
            md_cnt_nxt = '0;
            state_nxt  = RUN;
          end else begin
            ctrl       = CTRL_HOLD;
            stall_evt  = 1'b1;
            md_cnt_nxt = md_cnt - MD_W'(1);
          end
        end
        DRAIN: begin
          ctrl = CTRL_BUBBLE;
          if (drain_cnt <= DR_W'(1)) begin
            drain_nxt = '0;
            state_nxt = HALTED;
          end else begin
            drain_nxt = drain_cnt - DR_W'(1);
          end
        end
        default: begin
          ctrl = CTRL_STOP;
        end
      endcase
    end

    // Reset overrides the datapath controls immediately, not just at the next edge.
    if (!rst_i) begin
      ctrl    = CTRL_STOP;
      md_done = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_evt && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign pc_write_o    = ctrl.pc_write;
  assign ifid_write_o  = ctrl.ifid_write;
  assign ifid_flush_o  = ctrl.ifid_flush;
  assign idex_write_o  = ctrl.idex_write;
  assign idex_flush_o  = ctrl.idex_flush;
  assign exmem_flush_o = ctrl.exmem_flush;
  assign md_done_o     = md_done;
  assign halted_o      = (state == HALTED);
  assign stall_cnt_o   = stall_cnt;
  assign flush_cnt_o   = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: reference model feeds an expected queue; a narrow-counter instance covers saturation.
module tb_pipe_ctrl;

  localparam int MD_LAT    = 4;
  localparam int DRAIN_CYC = 3;
  localparam int W         = 76;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic [4:0] ifid_rs_i = '0;
  logic [4:0] ifid_rt_i = '0;
  logic       idex_memread_i = 1'b0;
  logic [4:0] idex_rt_i = '0;
  logic       idex_is_md_i = 1'b0;
  logic       branch_taken_i = 1'b0;
  logic       halt_i = 1'b0;

  logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_flush, md_done, halted;
  logic [31:0] stall_cnt, flush_cnt;
  logic s_pc_write, s_ifid_write, s_ifid_flush, s_idex_write, s_idex_flush, s_exmem_flush;
  logic s_md_done, s_halted;
  logic [1:0] s_stall_cnt, s_flush_cnt;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  int     m_state = 0;
  int     m_md_left = 0;
  int     m_drain = 0;
  longint m_stall = 0;
  longint m_flush = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MD_LAT(MD_LAT), .DRAIN_CYC(DRAIN_CYC), .REG_AW(5), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
    .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i), .idex_is_md_i(idex_is_md_i),
    .branch_taken_i(branch_taken_i), .halt_i(halt_i),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
    .idex_write_o(idex_write), .idex_flush_o(idex_flush), .exmem_flush_o(exmem_flush),
    .md_done_o(md_done), .halted_o(halted), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  pipe_ctrl #(.MD_LAT(MD_LAT), .DRAIN_CYC(DRAIN_CYC), .REG_AW(5), .CNT_W(2)) dut_s (
    .clk_i(clk), .rst_i(rst_i), .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
    .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i), .idex_is_md_i(idex_is_md_i),
    .branch_taken_i(branch_taken_i), .halt_i(halt_i),
    .pc_write_o(s_pc_write), .ifid_write_o(s_ifid_write), .ifid_flush_o(s_ifid_flush),
    .idex_write_o(s_idex_write), .idex_flush_o(s_idex_flush), .exmem_flush_o(s_exmem_flush),
    .md_done_o(s_md_done), .halted_o(s_halted), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
  );

  wire [7:0] d_ctrl = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_flush, md_done, halted};
  wire [7:0] s_ctrl = {s_pc_write, s_ifid_write, s_ifid_flush, s_idex_write, s_idex_flush,
                       s_exmem_flush, s_md_done, s_halted};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input longint v, input longint max);
    return (v > max) ? 32'(max) : 32'(v);
  endfunction

  // Reference model: one call per clock cycle, returns {controls, md_done, halted}.
  task automatic model_step(input logic br, md, lu, halt, output logic [7:0] c);
    logic [5:0] k;
    logic       done;
    int         pre;
    pre  = m_state;
    k    = 6'b110100;
    done = 1'b0;
    if (m_state == 3) begin
      k = 6'b001011;
    end else if (br) begin
      k = 6'b111111; m_flush++; m_state = 0;
    end else if (m_state == 1) begin
      if (m_md_left == 1) begin
        done = 1'b1; m_state = 0;
      end else begin
        k = 6'b000001; m_stall++; m_md_left--;
      end
    end else if (m_state == 2) begin
      k = 6'b000110; m_drain--;
      if (m_drain <= 0) m_state = 3;
    end else if (md) begin
      k = 6'b000001; m_stall++; m_md_left = MD_LAT - 1; m_state = 1;
    end else if (lu) begin
      k = 6'b000110; m_stall++;
    end else if (halt) begin
      m_state = 2; m_drain = DRAIN_CYC;
    end
    c = {k, done, (pre == 3)};
  endtask

  // Entered at posedge+1; returns at the following posedge+1.
  task automatic step(input logic br, md, mem, input logic [4:0] ex_rt, id_rs, id_rt, input logic halt);
    logic [7:0]   c;
    logic [W-1:0] e;
    logic         lu;
    logic [31:0]  st32, fl32;
    logic [1:0]   st2, fl2;
    branch_taken_i = br; idex_is_md_i = md; idex_memread_i = mem;
    idex_rt_i = ex_rt; ifid_rs_i = id_rs; ifid_rt_i = id_rt; halt_i = halt;
    lu   = mem && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    st32 = sat(m_stall, 64'hFFFF_FFFF);
    fl32 = sat(m_flush, 64'hFFFF_FFFF);
    st2  = 2'(sat(m_stall, 3));
    fl2  = 2'(sat(m_flush, 3));
    model_step(br, md, lu, halt, c);
    exp_q.push_back({c, st32, fl32, st2, fl2});
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq("ctrl", 32'(d_ctrl), 32'(e[75:68]));
    check_eq("s_ctrl", 32'(s_ctrl), 32'(e[75:68]));
    check_eq("stall_cnt", stall_cnt, e[67:36]);
    check_eq("flush_cnt", flush_cnt, e[35:4]);
    check_eq("s_cnts", {28'd0, s_stall_cnt, s_flush_cnt}, {28'd0, e[3:0]});
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // Entered at posedge+1; asserts reset asynchronously mid-cycle.
  task automatic do_reset();
    branch_taken_i = 1'b0; idex_is_md_i = 1'b0; idex_memread_i = 1'b0; halt_i = 1'b0;
    #1 rst_i = 1'b0;
    #1;
    check_eq("rst_ctrl", 32'(d_ctrl), 32'h2C);
    check_eq("rst_stall", stall_cnt, 32'd0);
    check_eq("rst_flush", flush_cnt, 32'd0);
    check_eq("rst_s_cnts", {28'd0, s_stall_cnt, s_flush_cnt}, 32'd0);
    m_state = 0; m_md_left = 0; m_drain = 0; m_stall = 0; m_flush = 0;
    @(posedge clk); #1;
    rst_i = 1'b1;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();

    // load-use on rs, then the bubble clears it
    step(1'b0, 1'b0, 1'b1, 5'd2, 5'd2, 5'd7, 1'b0);
    idle();
    check_eq("t1_stall", stall_cnt, 32'd1);
    // load into $0 is not a hazard; rt match also covered
    step(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    check_eq("t2_stall", stall_cnt, 32'd1);
    step(1'b0, 1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0);
    idle();

    // mul/div occupying EX for MD_LAT cycles
    for (int i = 0; i < MD_LAT; i++) step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check_eq("t3_stall", stall_cnt, 32'd5);
    idle();

    // branch aborts mul/div in its second cycle
    step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle();
    check_eq("t4_flush", flush_cnt, 32'd1);

    // halt, drain, stay halted even against a branch
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < DRAIN_CYC; i++) idle();
    step(1'b1, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0);
    idle();
    check_eq("t5_halted", 32'(halted), 32'd1);
    do_reset();
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    idle();
    idle();
    do_reset();

    // narrow counters saturate at 3
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd1, 1'b0);
    idle();
    check_eq("t6_s_stall", 32'(s_stall_cnt), 32'd3);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if (m_state == 3) do_reset();
      step($urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 30) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
